// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change payout path: money width,
// FSM state encoding, coin selection codes and denominations.
package change_dispenser_pkg;

    localparam int MONEY_W = 5;
    typedef logic [MONEY_W-1:0] money_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_REQ    = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    localparam logic [1:0] SEL_1  = 2'b00;
    localparam logic [1:0] SEL_5  = 2'b01;
    localparam logic [1:0] SEL_10 = 2'b10;

    localparam money_t DENOM_1  = 5'd1;
    localparam money_t DENOM_5  = 5'd5;
    localparam money_t DENOM_10 = 5'd10;

    // Largest coin code not exceeding the amount; zero maps to the 1-yuan code.
    function automatic logic [1:0] greedy_code(input money_t amt);
        logic [1:0] code;
        if (amt >= DENOM_10) begin
            code = SEL_10;
        end else if (amt >= DENOM_5) begin
            code = SEL_5;
        end else begin
            code = SEL_1;
        end
        return code;
    endfunction

endpackage

// File: rtl/change_dispenser_denom_sel.sv
// Combinational greedy coin chooser: picks the largest coin that fits in the
// amount still owed and reports its selection code and value.
module change_denom_sel
    import change_dispenser_pkg::*;
(
    input  logic [MONEY_W-1:0] remaining,
    output logic [1:0]         coin_sel,
    output logic [MONEY_W-1:0] denom
);

    // Map the selection code to its coin value.
    always_comb begin
        coin_sel = greedy_code(remaining);
        case (coin_sel)
            SEL_10:  denom = DENOM_10;
            SEL_5:   denom = DENOM_5;
            SEL_1:   denom = DENOM_1;
            default: denom = DENOM_1;
        endcase
    end

endmodule

// File: rtl/change_dispenser.sv
// Coin hopper driver: latches the change owed and pays it out greedily,
// one request/acknowledge handshake per coin, with ack timeout detection.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int GAP_CYCLES  = 4,
    parameter int ACK_TIMEOUT = 1000000,
    parameter int TIMER_W     = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [MONEY_W-1:0] change_in,
    input  logic               hopper_ack,
    input  logic               fault_clr,
    output logic               coin_req,
    output logic [1:0]         coin_sel,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [MONEY_W-1:0] remaining,
    output logic [MONEY_W-1:0] dispensed
);

    localparam logic [TIMER_W-1:0] TO_LAST  = TIMER_W'(ACK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST = TIMER_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
    localparam bit                 NO_GAP   = (GAP_CYCLES == 0);

    state_t             state_q,     state_d;
    logic [TIMER_W-1:0] timer_q,     timer_d;
    money_t             remaining_q, remaining_d;
    money_t             dispensed_q, dispensed_d;
    logic               coin_req_q,  coin_req_d;
    logic [1:0]         coin_sel_q,  coin_sel_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic               fault_q,     fault_d;

    logic [1:0]         sel_s;
    money_t             denom_s;

    change_denom_sel u_denom_sel (
        .remaining (remaining_q),
        .coin_sel  (sel_s),
        .denom     (denom_s)
    );

    // Next-state and next-output computation for the payout FSM.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        dispensed_d = dispensed_q;
        coin_req_d  = coin_req_q;
        coin_sel_d  = coin_sel_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        fault_d     = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d = change_in;
                    dispensed_d = 5'd0;
                    busy_d      = 1'b1;
                    state_d     = ST_SELECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (remaining_q == 5'd0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    coin_sel_d = sel_s;
                    timer_d    = '0;
                    coin_req_d = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                // An ack on the timeout cycle still counts the coin.
                if (hopper_ack) begin
                    remaining_d = remaining_q - denom_s;
                    dispensed_d = dispensed_q + denom_s;
                    coin_req_d  = 1'b0;
                    timer_d     = '0;
                    state_d     = NO_GAP ? ST_SELECT : ST_GAP;
                end else if (timer_q == TO_LAST) begin
                    coin_req_d = 1'b0;
                    busy_d     = 1'b0;
                    fault_d    = 1'b1;
                    state_d    = ST_FAULT;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            ST_GAP: begin
                if (timer_q == GAP_LAST) begin
                    state_d = ST_SELECT;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                // Counters stay frozen so the display can show where payout stopped.
                if (fault_clr) begin
                    fault_d     = 1'b0;
                    remaining_d = 5'd0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                coin_req_d = 1'b0;
                busy_d     = 1'b0;
                fault_d    = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            remaining_q <= 5'd0;
            dispensed_q <= 5'd0;
            coin_req_q  <= 1'b0;
            coin_sel_q  <= SEL_1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
            dispensed_q <= dispensed_d;
            coin_req_q  <= coin_req_d;
            coin_sel_q  <= coin_sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
        end
    end

    assign coin_req  = coin_req_q;
    assign coin_sel  = coin_sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign remaining = remaining_q;
    assign dispensed = dispensed_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: a hopper model answers coin
// requests while a queue of expected coins is checked at each handshake.
module tb_change_dispenser;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] change_in;
    logic       hopper_ack;
    logic       fault_clr;
    logic       coin_req;
    logic [1:0] coin_sel;
    logic       busy;
    logic       done;
    logic       fault;
    logic [4:0] remaining;
    logic [4:0] dispensed;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    change_dispenser #(.GAP_CYCLES(4), .ACK_TIMEOUT(8), .TIMER_W(20)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .change_in(change_in),
        .hopper_ack(hopper_ack), .fault_clr(fault_clr), .coin_req(coin_req),
        .coin_sel(coin_sel), .busy(busy), .done(done), .fault(fault),
        .remaining(remaining), .dispensed(dispensed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_greedy(input logic [4:0] chg);
        int r;
        r = int'(chg);
        while (r > 0) begin
            if (r >= 10) begin exp_q.push_back(2'b10); r -= 10; end
            else if (r >= 5) begin exp_q.push_back(2'b01); r -= 5; end
            else begin exp_q.push_back(2'b00); r -= 1; end
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({coin_req, coin_sel, busy, done, fault, remaining, dispensed} !== 17'd0) begin
            errors++;
            $display("FAIL %s: req=%0b sel=%0d busy=%0b done=%0b fault=%0b rem=%0d disp=%0d, required all 0",
                     tag, coin_req, coin_sel, busy, done, fault, remaining, dispensed);
        end
    endtask

    // Runs one transaction against the hopper model. delay<0 means never ack.
    task automatic do_payout(input logic [4:0] chg, input int delay, input bit held,
                             input bit stray, input int abort_n,
                             output int n_req, output int done_cyc, output int first_req,
                             output int period, output int min_low, output bit busy1);
        int cyc, age, low_run, last_rise, coins, since_ack;
        bit prev_req, ack;
        push_greedy(chg);
        n_req = 0; done_cyc = -1; first_req = -1; period = 0; min_low = 1000; busy1 = 1'b0;
        prev_req = 1'b0; age = 0; low_run = 0; last_rise = -1; coins = 0; since_ack = 100;
        hopper_ack = held;
        @(posedge clk); #1 change_in = chg; start = 1'b1;
        @(posedge clk); #1 start = 1'b0; cyc = 1;
        while (1) begin
            if (cyc > 400) begin
                checks++; errors++;
                $display("FAIL payout_timeout: no done after %0d cycles, required done", cyc);
                break;
            end
            if (cyc == 1) busy1 = busy;
            if (done) begin done_cyc = cyc; break; end
            if (coin_req && !prev_req) begin
                n_req++;
                if (first_req < 0) first_req = cyc;
                else if (period == 0) period = cyc - last_rise;
                if (n_req > 1 && low_run < min_low) min_low = low_run;
                last_rise = cyc;
            end
            low_run = coin_req ? 0 : low_run + 1;
            age = coin_req ? (prev_req ? age + 1 : 0) : 0;
            ack = held || (coin_req && delay >= 0 && age == delay);
            if (stray && !coin_req && busy && since_ack == 2) ack = 1'b1;
            if (stray && cyc == 5) begin start = 1'b1; change_in = 5'd9; end
            else start = 1'b0;
            hopper_ack = ack;
            since_ack++;
            if (coin_req && ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL coin_extra: coin_sel=%0d requested, required no more coins", coin_sel);
                end else begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    if (coin_sel !== e) begin
                        errors++;
                        $display("FAIL coin_sel: got %0d, required %0d", coin_sel, e);
                    end
                end
                coins++;
                since_ack = 0;
            end
            if (busy) begin
                checks++;
                if ({1'b0, dispensed} + {1'b0, remaining} !== {1'b0, chg}) begin
                    errors++;
                    $display("FAIL conservation: disp=%0d rem=%0d, required sum %0d", dispensed, remaining, chg);
                end
            end
            prev_req = coin_req;
            @(posedge clk); #1 cyc++;
            if (abort_n > 0 && coins == abort_n) break;
        end
        hopper_ack = 1'b0; start = 1'b0;
    endtask

    task automatic check_done_state(input string tag, input logic [4:0] exp_disp,
                                    input int n_req, input int exp_req);
        checks++;
        if (n_req != exp_req || dispensed !== exp_disp || remaining !== 5'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: reqs=%0d disp=%0d rem=%0d left=%0d, required reqs=%0d disp=%0d rem=0 left=0",
                     tag, n_req, dispensed, remaining, exp_q.size(), exp_req, exp_disp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; change_in = 5'd0; hopper_ack = 1'b0; fault_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset_values");
        #3 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int n_req, dc, fr, per, ml;
        bit b1;
        do_payout(5'd17, 2, 1'b0, 1'b0, 0, n_req, dc, fr, per, ml, b1);
        check_done_state("basic_final", 5'd17, n_req, 4);
        checks++;
        if (b1 !== 1'b1 || fr != 2 || per != 8 || dc != 34) begin
            errors++;
            $display("FAIL basic_timing: busy1=%0b first_req=%0d period=%0d done=%0d, required 1/2/8/34",
                     b1, fr, per, dc);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_done: busy=%0b in done cycle, required 0", busy);
        end
    endtask

    task automatic test_stray();
        int n_req, dc, fr, per, ml;
        bit b1;
        @(posedge clk); #1 hopper_ack = 1'b1;
        @(posedge clk); #1 hopper_ack = 1'b0;
        checks++;
        if (remaining !== 5'd0 || dispensed !== 5'd17 || coin_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack_idle: rem=%0d disp=%0d req=%0b busy=%0b, required 0/17/0/0",
                     remaining, dispensed, coin_req, busy);
        end
        do_payout(5'd17, 2, 1'b0, 1'b1, 0, n_req, dc, fr, per, ml, b1);
        check_done_state("stray_final", 5'd17, n_req, 4);
        checks++;
        if (dc != 34) begin
            errors++;
            $display("FAIL stray_done_cycle: got %0d, required 34", dc);
        end
    endtask

    task automatic test_zero();
        int n_req, dc, fr, per, ml;
        bit b1;
        do_payout(5'd0, 2, 1'b0, 1'b0, 0, n_req, dc, fr, per, ml, b1);
        check_done_state("zero_final", 5'd0, n_req, 0);
        checks++;
        if (b1 !== 1'b1 || dc != 2) begin
            errors++;
            $display("FAIL zero_timing: busy1=%0b done_cycle=%0d, required 1/2", b1, dc);
        end
    endtask

    task automatic test_held_ack();
        int n_req, dc, fr, per, ml;
        bit b1;
        do_payout(5'd31, 0, 1'b1, 1'b0, 0, n_req, dc, fr, per, ml, b1);
        check_done_state("held_final", 5'd31, n_req, 4);
        checks++;
        if (ml != 5 || per != 6) begin
            errors++;
            $display("FAIL held_gap: min_low=%0d period=%0d, required 5/6", ml, per);
        end
    endtask

    task automatic test_timeout();
        int cyc, req_cyc, fault_cyc;
        push_greedy(5'd6);
        exp_q.delete();
        @(posedge clk); #1 change_in = 5'd6; start = 1'b1;
        @(posedge clk); #1 start = 1'b0; cyc = 1; req_cyc = -1; fault_cyc = -1;
        while (cyc < 60 && fault_cyc < 0) begin
            if (coin_req && req_cyc < 0) req_cyc = cyc;
            if (fault) fault_cyc = cyc;
            else begin @(posedge clk); #1 cyc++; end
        end
        checks++;
        if (req_cyc != 2 || fault_cyc - req_cyc != 8) begin
            errors++;
            $display("FAIL timeout_cycle: req at %0d fault at %0d, required 2 and 10", req_cyc, fault_cyc);
        end
        checks++;
        if (coin_req !== 1'b0 || busy !== 1'b0 || remaining !== 5'd6 || dispensed !== 5'd0) begin
            errors++;
            $display("FAIL timeout_state: req=%0b busy=%0b rem=%0d disp=%0d, required 0/0/6/0",
                     coin_req, busy, remaining, dispensed);
        end
        change_in = 5'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (fault !== 1'b1 || remaining !== 5'd6 || busy !== 1'b0 || coin_req !== 1'b0) begin
            errors++;
            $display("FAIL fault_start_ignored: fault=%0b rem=%0d busy=%0b req=%0b, required 1/6/0/0",
                     fault, remaining, busy, coin_req);
        end
        fault_clr = 1'b1;
        @(posedge clk); #1 fault_clr = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (fault !== 1'b0 || remaining !== 5'd0 || busy !== 1'b0 || dispensed !== 5'd0) begin
            errors++;
            $display("FAIL fault_clear: fault=%0b rem=%0d busy=%0b disp=%0d, required 0/0/0/0",
                     fault, remaining, busy, dispensed);
        end
    endtask

    task automatic test_reset_mid();
        int n_req, dc, fr, per, ml;
        bit b1;
        do_payout(5'd31, 2, 1'b0, 1'b0, 1, n_req, dc, fr, per, ml, b1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_mid_async");
        exp_q.delete();
        #2 rst_n = 1'b1;
        do_payout(5'd5, 2, 1'b0, 1'b0, 0, n_req, dc, fr, per, ml, b1);
        check_done_state("after_reset_5", 5'd5, n_req, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stray();
        test_zero();
        test_held_ack();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
